// File: rtl/demux_1x16_reg.sv
// demux_1x16_reg: registered 1-to-N_OUT demultiplexer.
// Each output channel is a one-entry holding buffer with a valid/ack handshake.
// The input is steered to channel s.
// Optional feature macro: DEMUX_OCC_CNT_EN adds the occ_cnt/occ_full occupancy outputs.
module demux_1x16_reg #(
    parameter int WIDTH = 32,
    parameter int SEL_W = 4,
    parameter int N_OUT = 16      // must equal 2**SEL_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       din,
    input  logic [SEL_W-1:0]       s,
    input  logic                   din_valid,
    output logic                   din_ready,
    output logic [N_OUT*WIDTH-1:0] dout,
    output logic [N_OUT-1:0]       dout_valid,
    input  logic [N_OUT-1:0]       dout_ack
`ifdef DEMUX_OCC_CNT_EN
    ,
    output logic [SEL_W:0]         occ_cnt,
    output logic                   occ_full
`endif
);

    logic [WIDTH-1:0] dout_q [N_OUT];
    logic [WIDTH-1:0] dout_d [N_OUT];
    logic [N_OUT-1:0] dout_valid_q;
    logic [N_OUT-1:0] dout_valid_d;
    logic             accept;

    // The selected channel can take a word if it is empty or is being drained this cycle.
    assign din_ready = !dout_valid_q[s] || dout_ack[s];
    assign accept    = din_valid && din_ready;

    // Next-state for every channel: consumes first, then an accept overrides its own channel.
    always_comb begin
        // NOTE: every always_comb target gets a full default first so no latch is inferred.
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        for (int i = 0; i < N_OUT; i++) begin
            if (dout_ack[i] && dout_valid_q[i]) begin
                dout_valid_d[i] = 1'b0;
            end
        end
        if (accept) begin
            dout_d[s]       = din;
            dout_valid_d[s] = 1'b1;
        end
    end

    // Channel state registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so all flops sample together.
        if (rst) begin
            // NOTE: the data buffers are reset too, because consumers see all-zero data after reset.
            for (int i = 0; i < N_OUT; i++) begin
                dout_q[i] <= '0;
            end
            dout_valid_q <= '0;
        end else begin
            for (int i = 0; i < N_OUT; i++) begin
                dout_q[i] <= dout_d[i];
            end
            dout_valid_q <= dout_valid_d;
        end
    end

    // Flatten the channel buffers onto the output bus.
    always_comb begin
        dout = '0;
        for (int i = 0; i < N_OUT; i++) begin
            dout[i*WIDTH +: WIDTH] = dout_q[i];
        end
    end

    assign dout_valid = dout_valid_q;

`ifdef DEMUX_OCC_CNT_EN
    logic [SEL_W:0] occ_cnt_q;
    logic [SEL_W:0] occ_cnt_d;
    logic           occ_full_q;
    logic           occ_full_d;

    // Occupancy follows the next valid vector, so it updates on the same edge as dout_valid.
    always_comb begin
        occ_cnt_d = '0;
        for (int i = 0; i < N_OUT; i++) begin
            occ_cnt_d = occ_cnt_d + {{SEL_W{1'b0}}, dout_valid_d[i]};
        end
        occ_full_d = (occ_cnt_d == (SEL_W+1)'(N_OUT));
    end

    // Occupancy registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_cnt_q  <= '0;
            occ_full_q <= 1'b0;
        end else begin
            occ_cnt_q  <= occ_cnt_d;
            occ_full_q <= occ_full_d;
        end
    end

    assign occ_cnt  = occ_cnt_q;
    assign occ_full = occ_full_q;
`endif

endmodule
